param_instruction_ram_loader: RTL and testbench

//   Parametrised instruction memory for the processor fetch stage, with a sequential loader port.
//   One read port serves fetch. A direct write port supports single-word patching.
//   A valid/ready streaming loader fills a contiguous program image from a base address and reports completion and overflow.

---
 rtl/param_instruction_ram_loader.sv | 190 +++++++++++++++++++
 tb/tb_param_instruction_ram_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_instruction_ram_loader.sv
// Instruction RAM for the fetch stage: one fetch read port, a direct patch write port,
// and a valid/ready streaming loader that fills a contiguous image from a base address.
module param_instruction_ram_loader #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int DEPTH        = 872,
   parameter int READ_LATENCY = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] fetch_address,
   output logic [DATA_WIDTH-1:0] fetch_data,
   output logic                  fetch_fault,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH-1:0] load_base,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  load_ready,
   output logic                  load_busy,
   output logic                  load_done,
   output logic                  load_overflow,
   output logic [ADDR_WIDTH:0]   load_count
);

   // One extra bit so that DEPTH == 2**ADDR_WIDTH is still representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [ADDR_WIDTH:0]   ptr_r;
   logic [ADDR_WIDTH:0]   count_r;
   logic                  overflow_r;
   logic                  ready_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  accept_s;
   logic                  drop_s;
   logic                  mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_waddr_s;
   logic [DATA_WIDTH-1:0] mem_wdata_s;
   logic                  fetch_in_range_s;
   logic [DATA_WIDTH-1:0] fetch_word_s;
   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Loader next-state decode; a word offered at ptr >= DEPTH ends the session instead of wrapping.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      drop_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (load_start) begin
               state_s = LOAD;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            if (load_valid) begin
               if (ptr_r >= DEPTH_L) begin
                  drop_s  = 1'b1;
                  state_s = IDLE;
               end else begin
                  accept_s = 1'b1;
                  if (load_last) begin
                     state_s = DONE;
                  end else begin
                     state_s = LOAD;
                  end
               end
            end else begin
               state_s = LOAD;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register, session pointer/count and registered status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= IDLE;
         ptr_r      <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
         ready_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == LOAD);
         busy_r  <= (state_s != IDLE);
         done_r  <= (state_s == DONE);
         if ((state_r == IDLE) && load_start) begin
            ptr_r      <= {1'b0, load_base};
            count_r    <= '0;
            overflow_r <= 1'b0;
         end else if (accept_s) begin
            ptr_r   <= ptr_r + (ADDR_WIDTH+1)'(1);
            count_r <= count_r + (ADDR_WIDTH+1)'(1);
         end else if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Single memory write port: loader first, direct patches only while the loader is idle.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = '0;
      mem_wdata_s = '0;
      if (reset) begin
         mem_we_s = 1'b0;
      end else if (accept_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = ptr_r[ADDR_WIDTH-1:0];
         mem_wdata_s = load_data;
      end else if (write_enable && !busy_r && ({1'b0, write_address} < DEPTH_L)) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = write_address;
         mem_wdata_s = write_data;
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Memory array, intentionally without reset so contents survive a reset.
   always_ff @(posedge clock) begin
      if (mem_we_s) begin
         mem_r[mem_waddr_s] <= mem_wdata_s;
      end
   end

   assign fetch_in_range_s = ({1'b0, fetch_address} < DEPTH_L);

   // Out-of-range fetches read as zero.
   always_comb begin
      if (fetch_in_range_s) begin
         fetch_word_s = mem_r[fetch_address];
      end else begin
         fetch_word_s = '0;
      end
   end

   generate
      if (READ_LATENCY == 0) begin : g_lat0
         assign fetch_data  = fetch_word_s;
         assign fetch_fault = !fetch_in_range_s;
      end else begin : g_lat1
         logic [DATA_WIDTH-1:0] fetch_data_r;
         logic                  fetch_fault_r;

         // Registered read-first fetch: sampled before this edge's write lands.
         always_ff @(posedge clock) begin
            if (reset) begin
               fetch_data_r  <= '0;
               fetch_fault_r <= 1'b0;
            end else begin
               fetch_data_r  <= fetch_word_s;
               fetch_fault_r <= !fetch_in_range_s;
            end
         end

         assign fetch_data  = fetch_data_r;
         assign fetch_fault = fetch_fault_r;
      end
   endgenerate

   assign load_ready    = ready_r;
   assign load_busy     = busy_r;
   assign load_done     = done_r;
   assign load_overflow = overflow_r;
   assign load_count    = count_r;

endmodule

// File: tb/tb_param_instruction_ram_loader.sv
// Randomised bench for param_instruction_ram_loader: a combinational-fetch and a registered-fetch
// instance share stimulus and are checked every cycle against a session-level model.
module tb_param_instruction_ram_loader;

   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int DEPTH = 872;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] fetch_address;
   logic          write_enable;
   logic [AW-1:0] write_address;
   logic [DW-1:0] write_data;
   logic          load_start;
   logic [AW-1:0] load_base;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_last;

   logic [DW-1:0] fd0, fd1;
   logic          ff0, ff1, rdy0, rdy1, busy0, busy1, done0, done1, ovf0, ovf1;
   logic [AW:0]   cnt0, cnt1;

   param_instruction_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(0)) dut0 (
      .clock(clock), .reset(reset), .fetch_address(fetch_address), .fetch_data(fd0), .fetch_fault(ff0),
      .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
      .load_start(load_start), .load_base(load_base), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(rdy0), .load_busy(busy0), .load_done(done0),
      .load_overflow(ovf0), .load_count(cnt0));

   param_instruction_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
      .clock(clock), .reset(reset), .fetch_address(fetch_address), .fetch_data(fd1), .fetch_fault(ff1),
      .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
      .load_start(load_start), .load_base(load_base), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(rdy1), .load_busy(busy1), .load_done(done1),
      .load_overflow(ovf1), .load_count(cnt1));

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Session-level model: 0 = no session, 1 = accepting words, 2 = completion pulse cycle.
   int            m_phase = 0;
   int            m_ptr   = 0;
   int            m_count = 0;
   bit            m_over  = 1'b0;
   logic [DW-1:0] m_mem   [1024];
   bit            m_known [1024];
   logic [DW-1:0] m_l1_data  = '0;
   bit            m_l1_fault = 1'b0;
   bit            m_l1_known = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mem_write(input int a, input logic [DW-1:0] d);
      m_mem[a]   = d;
      m_known[a] = 1'b1;
   endtask

   task automatic model_edge();
      int fa;
      fa = int'(fetch_address);
      if (reset) begin
         m_phase    = 0;
         m_count    = 0;
         m_over     = 1'b0;
         m_l1_data  = '0;
         m_l1_fault = 1'b0;
         m_l1_known = 1'b1;
      end else begin
         if (fa < DEPTH) begin
            m_l1_data  = m_mem[fa];
            m_l1_known = m_known[fa];
            m_l1_fault = 1'b0;
         end else begin
            m_l1_data  = '0;
            m_l1_known = 1'b1;
            m_l1_fault = 1'b1;
         end
         if (write_enable && m_phase == 0 && int'(write_address) < DEPTH)
            mem_write(int'(write_address), write_data);
         case (m_phase)
            0: if (load_start) begin
                  m_phase = 1;
                  m_ptr   = int'(load_base);
                  m_count = 0;
                  m_over  = 1'b0;
               end
            1: if (load_valid) begin
                  if (m_ptr >= DEPTH) begin
                     m_over  = 1'b1;
                     m_phase = 0;
                  end else begin
                     mem_write(m_ptr, load_data);
                     m_ptr++;
                     m_count++;
                     if (load_last) m_phase = 2;
                  end
               end
            default: m_phase = 0;
         endcase
      end
   endtask

   task automatic compare_all();
      logic [DW-1:0] e0;
      bit            k0;
      if (int'(fetch_address) < DEPTH) begin
         e0 = m_mem[fetch_address];
         k0 = m_known[fetch_address];
      end else begin
         e0 = '0;
         k0 = 1'b1;
      end
      check("ready0", rdy0, m_phase == 1);
      check("ready1", rdy1, m_phase == 1);
      check("busy0", busy0, m_phase != 0);
      check("busy1", busy1, m_phase != 0);
      check("done0", done0, m_phase == 2);
      check("done1", done1, m_phase == 2);
      check("overflow0", ovf0, m_over);
      check("overflow1", ovf1, m_over);
      check("count0", cnt0, m_count);
      check("count1", cnt1, m_count);
      check("fault0", ff0, int'(fetch_address) >= DEPTH);
      if (k0) check("fetch0", fd0, e0);
      check("fault1", ff1, m_l1_fault);
      if (m_l1_known) check("fetch1", fd1, m_l1_data);
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      compare_all();
   endtask

   task automatic quiet();
      reset        = 1'b0;
      load_start   = 1'b0;
      load_valid   = 1'b0;
      load_last    = 1'b0;
      write_enable = 1'b0;
   endtask

   initial begin
      int ready_cycles;
      bit saw_done;
      bit [4:0] vpat;
      int widx;

      quiet();
      reset = 1'b1;
      fetch_address = '0; write_address = '0; write_data = '0;
      load_base = '0; load_data = '0;
      step();
      step();
      check("rst_ready", rdy0, 1'b0);
      check("rst_busy", busy0, 1'b0);
      check("rst_count", cnt0, 11'd0);
      check("rst_fetch1", fd1, 32'h0);

      // Give every word a known value.
      quiet();
      for (int i = 0; i < DEPTH; i++) begin
         write_enable = 1'b1; write_address = AW'(i); write_data = 32'h1000_0000 + i;
         step();
      end
      quiet();

      // Test 1: three-word load at base 0.
      ready_cycles = 0;
      load_start = 1'b1; load_base = '0;
      step();
      load_start = 1'b0;
      if (rdy0) ready_cycles++;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1; load_data = 32'hA0 + i; load_last = (i == 2);
         step();
         if (rdy0) ready_cycles++;
      end
      check("t1_done", done0, 1'b1);
      check("t1_count", cnt0, 11'd3);
      check("t1_ready_cycles", ready_cycles, 3);
      quiet();
      step();
      check("t1_done_gone", done0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         fetch_address = AW'(i);
         step();
         check("t1_mem", fd0, 32'hA0 + i);
      end

      // Test 2: registered fetch is read-first under a same-cycle write.
      write_enable = 1'b1; write_address = 10'd5; write_data = 32'h1;
      step();
      fetch_address = 10'd5; write_data = 32'hBEEF;
      step();
      check("t2_old_word", fd1, 32'h1);
      check("t2_lat0_new", fd0, 32'hBEEF);
      write_enable = 1'b0;
      step();
      check("t2_new_word", fd1, 32'hBEEF);

      // Test 3: overflow at the top of memory.
      quiet();
      saw_done = 1'b0;
      load_start = 1'b1; load_base = 10'd870;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1; load_data = 32'hC0 + i; load_last = (i == 3);
         step();
         if (done0) saw_done = 1'b1;
      end
      quiet();
      step();
      check("t3_overflow", ovf0, 1'b1);
      check("t3_count", cnt0, 11'd2);
      check("t3_no_done", saw_done, 1'b0);
      fetch_address = 10'd871;
      step();
      check("t3_mem871", fd0, 32'hC1);

      // Test 4: reset aborts a session, written words remain.
      load_start = 1'b1; load_base = 10'd100;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1; load_data = 32'hD0 + i;
         step();
      end
      load_valid = 1'b0; reset = 1'b1;
      step();
      check("t4_busy", busy0, 1'b0);
      check("t4_ready", rdy0, 1'b0);
      check("t4_count", cnt0, 11'd0);
      reset = 1'b0; fetch_address = 10'd101;
      step();
      check("t4_mem101", fd0, 32'hD1);

      // Test 5: direct write ignored while loading; out-of-range fetch.
      load_start = 1'b1; load_base = 10'd200;
      step();
      load_start = 1'b0;
      write_enable = 1'b1; write_address = 10'd0; write_data = 32'hDEAD;
      step();
      write_enable = 1'b0;
      load_valid = 1'b1; load_last = 1'b1; load_data = 32'hE0;
      step();
      quiet();
      fetch_address = 10'd0;
      step();
      check("t5_mem0_kept", fd0, 32'hA0);
      fetch_address = 10'd900;
      step();
      check("t5_fetch0", fd0, 32'h0);
      check("t5_fault0", ff0, 1'b1);
      check("t5_fault1", ff1, 1'b1);

      // Test 6: valid gaps, last on the third accepted word.
      load_start = 1'b1; load_base = 10'd300;
      step();
      load_start = 1'b0;
      vpat = 5'b11001;
      widx = 0;
      for (int i = 0; i < 5; i++) begin
         load_valid = vpat[i];
         load_data  = 32'hF0 + widx;
         load_last  = vpat[i] && (widx == 2);
         if (i == 4) check("t6_no_early_done", done0, 1'b0);
         step();
         if (vpat[i]) widx++;
      end
      check("t6_done", done0, 1'b1);
      check("t6_count", cnt0, 11'd3);
      quiet();
      fetch_address = 10'd302;
      step();
      check("t6_mem302", fd0, 32'hF2);

      // Randomised traffic.
      for (int c = 0; c < 3000; c++) begin
         quiet();
         reset         = ($urandom_range(199) == 0);
         load_start    = ($urandom_range(7) == 0);
         load_base     = ($urandom_range(3) == 0) ? AW'($urandom_range(1023, DEPTH - 6))
                                                  : AW'($urandom_range(DEPTH - 1));
         load_valid    = ($urandom_range(1) == 0);
         load_data     = $urandom;
         load_last     = ($urandom_range(9) == 0);
         write_enable  = ($urandom_range(3) == 0);
         write_address = AW'($urandom_range(1023));
         write_data    = $urandom;
         fetch_address = AW'($urandom_range(1023));
         if (reset) begin
            load_valid   = 1'b0;
            write_enable = 1'b0;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
